// File: rtl/wb_data_select.sv
// Register-file write-back source selector: slot mux, load byte/half extraction, registered valid/ready output.
// Optional macro WB_DATA_SKID_EN adds a 2-entry skid buffer with a registered in_ready.
module wb_data_select #(
    parameter int          DATA_W    = 32,
    parameter int          NUM_SRC   = 7,
    parameter int          SEL_W     = 3,
    parameter int          CONST_IDX = 5,
    parameter logic [31:0] CONST_VAL = 32'd227
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [1:0]                ld_size,
    input  logic                      ld_unsigned,
    input  logic [1:0]                ld_offset,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         wb_data,
    output logic                      sel_err,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [31:0]       w_ld_word;
    logic [15:0]       w_ld_half;
    logic [7:0]        w_ld_byte;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_ld_err;
    logic [DATA_W-1:0] w_slot;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_err;
    logic              w_accept;
    logic              w_drain;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_sel_err;

    // Load path: little-endian lanes taken from the low word of slot 0.
    assign w_ld_word = src_bus[31:0];
    assign w_ld_half = ld_offset[1] ? w_ld_word[31:16] : w_ld_word[15:0];

    always_comb begin
        w_ld_byte = w_ld_word[7:0];
        case (ld_offset)
            2'd1:    w_ld_byte = w_ld_word[15:8];
            2'd2:    w_ld_byte = w_ld_word[23:16];
            2'd3:    w_ld_byte = w_ld_word[31:24];
            default: w_ld_byte = w_ld_word[7:0];
        endcase
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        w_ld_data = '0;
        w_ld_err  = 1'b0;
        case (ld_size)
            2'b00: begin
                w_ld_data       = {DATA_W{!ld_unsigned & w_ld_word[31]}};
                w_ld_data[31:0] = w_ld_word;
            end
            2'b01: begin
                if (ld_offset[0]) begin
                    w_ld_err = 1'b1;
                end else begin
                    w_ld_data       = {DATA_W{!ld_unsigned & w_ld_half[15]}};
                    w_ld_data[15:0] = w_ld_half;
                end
            end
            2'b10: begin
                w_ld_data      = {DATA_W{!ld_unsigned & w_ld_byte[7]}};
                w_ld_data[7:0] = w_ld_byte;
            end
            default: w_ld_err = 1'b1;
        endcase
    end

    always_comb begin
        w_slot = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(src_sel) == k) w_slot = src_bus[k*DATA_W +: DATA_W];
        end
    end

    // Out-of-range select wins; the constant slot overrides both the bus and the load path.
    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b0;
        if (int'(src_sel) >= NUM_SRC) begin
            w_sel_err = 1'b1;
        end else if (int'(src_sel) == CONST_IDX) begin
            w_sel_data = DATA_W'(CONST_VAL);
        end else if (src_sel == '0) begin
            w_sel_data = w_ld_data;
            w_sel_err  = w_ld_err;
        end else begin
            w_sel_data = w_slot;
        end
    end

    assign w_accept  = in_valid & in_ready;
    assign w_drain   = r_out_valid & out_ready;
    assign out_valid = r_out_valid;
    assign wb_data   = r_wb_data;
    assign sel_err   = r_sel_err;

`ifdef WB_DATA_SKID_EN
    logic              r_in_ready;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_err;

    assign in_ready = r_in_ready;

    // The skid entry only fills while the output is stalled, so it is empty whenever the output is.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_wb_data    <= '0;
            r_sel_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (!r_out_valid || w_drain) begin
            if (r_skid_valid) begin
                r_wb_data    <= r_skid_data;
                r_sel_err    <= r_skid_err;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_wb_data   <= w_sel_data;
                r_sel_err   <= w_sel_err;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: payload-only storage is not reset; r_skid_valid alone says whether it means anything.
        if (w_accept && r_out_valid && !out_ready) begin
            r_skid_data <= w_sel_data;
            r_skid_err  <= w_sel_err;
        end
    end
`else
    assign in_ready = !r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_out_valid <= 1'b0;
            r_wb_data   <= '0;
            r_sel_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_wb_data   <= w_sel_data;
            r_sel_err   <= w_sel_err;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

endmodule
